// File: rtl/adc_block_averager_if.sv
// Sample, control and result bundle of the ADC block averager. The master side
// supplies samples and control; the slave side is the averager itself.
interface adc_block_averager_if #(
  parameter int ADC_WIDTH  = 12,
  parameter int NUM_CH     = 2,
  parameter int MAX_LOG2_N = 14
);
  logic [NUM_CH*ADC_WIDTH-1:0]              ADC_DATA_IN;
  logic                                     SAMPLE_VALID;
  logic [4:0]                               LOG2_N;
  logic                                     START;
  logic                                     CONTINUOUS;
  logic                                     ABORT;
  logic [NUM_CH*(ADC_WIDTH+MAX_LOG2_N)-1:0] SUM_OUT;
  logic [NUM_CH*ADC_WIDTH-1:0]              AVG_OUT;
  logic                                     DONE;
  logic                                     BUSY;

  modport master (
    output ADC_DATA_IN, SAMPLE_VALID, LOG2_N, START, CONTINUOUS, ABORT,
    input  SUM_OUT, AVG_OUT, DONE, BUSY
  );

  modport slave (
    input  ADC_DATA_IN, SAMPLE_VALID, LOG2_N, START, CONTINUOUS, ABORT,
    output SUM_OUT, AVG_OUT, DONE, BUSY
  );
endinterface

// File: rtl/adc_block_averager.sv
// Multi-channel ADC block averager: accumulates 2^L samples per channel and
// publishes the block sums and rounded means together with a one-cycle DONE.
module adc_block_averager #(
  parameter int ADC_WIDTH  = 12,
  parameter int NUM_CH     = 2,
  parameter int MAX_LOG2_N = 14,
  parameter int SIGNED_IN  = 1
) (
  input  logic                ADC_CLK,
  input  logic                RST,
  adc_block_averager_if.slave bus
);
  localparam int   SW        = ADC_WIDTH + MAX_LOG2_N;
  localparam int   RW        = SW + 1;
  localparam int   CW        = MAX_LOG2_N + 1;
  localparam int   LW        = $clog2(MAX_LOG2_N + 1);
  localparam logic IS_SIGNED = (SIGNED_IN != 32'sd0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                       state_r;
  logic [LW-1:0]                len_r;
  logic [CW-1:0]                cnt_r;
  logic [NUM_CH-1:0][SW-1:0]    acc_r;
  logic [NUM_CH*SW-1:0]         sum_out_r;
  logic [NUM_CH*ADC_WIDTH-1:0]  avg_out_r;
  logic                         done_r;
  logic                         busy_r;

  logic [LW-1:0]                len_req_s;
  logic                         last_s;
  logic signed [RW-1:0]         rnd_s;
  logic [ADC_WIDTH-1:0]         sample_s;
  logic signed [RW-1:0]         wide_s;
  logic [NUM_CH-1:0][SW-1:0]    sum_next_s;
  logic [NUM_CH*ADC_WIDTH-1:0]  avg_s;

  // Requested block length, clamped to the largest supported length.
  always_comb begin
    if (bus.LOG2_N > 5'(MAX_LOG2_N)) begin
      len_req_s = LW'(MAX_LOG2_N);
    end else begin
      len_req_s = LW'(bus.LOG2_N);
    end
  end

  // Rounding bias of half an LSB of the mean; zero for single-sample blocks.
  always_comb begin
    if (len_r == '0) begin
      rnd_s = '0;
    end else begin
      rnd_s = RW'(1'b1) << (len_r - LW'(1'b1));
    end
  end

  assign last_s = (cnt_r == ((CW'(1'b1) << len_r) - CW'(1'b1)));

  // Per-channel running sums including this cycle's sample, and the rounded
  // mean those sums would give if this sample closes the block.
  always_comb begin
    sum_next_s = '0;
    avg_s      = '0;
    sample_s   = '0;
    wide_s     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sample_s      = bus.ADC_DATA_IN[c*ADC_WIDTH +: ADC_WIDTH];
      sum_next_s[c] = acc_r[c] + {{MAX_LOG2_N{sample_s[ADC_WIDTH-1] & IS_SIGNED}}, sample_s};
      // One guard bit keeps the biased sum from wrapping before the shift.
      wide_s        = {sum_next_s[c][SW-1] & IS_SIGNED, sum_next_s[c]} + rnd_s;
      avg_s[c*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(wide_s >>> len_r);
    end
  end

  // Block FSM, accumulators and registered result outputs.
  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      len_r     <= '0;
      cnt_r     <= '0;
      acc_r     <= '0;
      sum_out_r <= '0;
      avg_out_r <= '0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.ABORT) begin
            cnt_r <= '0;
          end else if (bus.START || bus.CONTINUOUS) begin
            state_r <= ACCUM;
            busy_r  <= 1'b1;
            len_r   <= len_req_s;
            cnt_r   <= '0;
            acc_r   <= '0;
          end else begin
            cnt_r <= '0;
          end
        end
        ACCUM: begin
          if (bus.ABORT) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
          end else if (bus.SAMPLE_VALID) begin
            if (last_s) begin
              sum_out_r <= sum_next_s;
              avg_out_r <= avg_s;
              done_r    <= 1'b1;
              cnt_r     <= '0;
              acc_r     <= '0;
              // Continuous mode re-arms immediately so the next sample is kept.
              if (bus.CONTINUOUS) begin
                len_r <= len_req_s;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              acc_r <= sum_next_s;
              cnt_r <= cnt_r + CW'(1'b1);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.SUM_OUT = sum_out_r;
  assign bus.AVG_OUT = avg_out_r;
  assign bus.DONE    = done_r;
  assign bus.BUSY    = busy_r;
endmodule
